alu_issue_ctrl: RTL and testbench

- Issue and writeback controller that sits upstream of the DLX ALU.
- Accepts one 32-bit DLX R-type or I-type ALU instruction per valid/ready handshake and decodes it into the ALU's 4-bit operation code.
- Reads operands from an internal 32x32 register file, drives the ALU for one EX cycle, then waits the ALU latency.
- Writes the result back to rd and latches the carry and zero flags.

---
 rtl/alu_issue_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// ----------------------------------------------------------------------------
// Issue/writeback controller sitting in front of the DLX ALU. One R-type or
// I-type ALU instruction is accepted per valid/ready handshake, decoded into
// the ALU operation code, and its operands are read from a 32 x XLEN register
// file. The ALU is strobed for one EX cycle, the controller then waits
// ALU_LATENCY cycles, writes the result back to rd and latches carry/zero.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_valid/instr_ready instruction handshake, instr = DLX word
//   alu_I, alu_EX           ALU operation code and execute strobe
//   alu_op1, alu_op2        ALU operands (held stable until the next accept)
//   alu_res/carry/z         ALU result inputs
//   done, illegal           one-cycle completion / drop pulses
//   flag_c, flag_z          flags of the last executed instruction
//   dbg_addr, dbg_data      combinational register-file debug read
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int XLEN        = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [3:0]      alu_I,
    output logic            alu_EX,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_carry,
    input  logic            alu_z,
    output logic            done,
    output logic            illegal,
    output logic            flag_c,
    output logic            flag_z,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ILL
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [3:0]        alu_i_reg;
    logic [XLEN-1:0]   op1_reg, op2_reg;
    logic [4:0]        rd_reg;
    logic              flag_c_reg, flag_z_reg;

    logic              accept;
    logic              wb_en;
    logic              dec_legal;
    logic [3:0]        dec_code;
    logic [4:0]        dec_rd;
    logic [XLEN-1:0]   dec_op1, dec_op2;

    // ------------------------------------------------------------------
    // Register file. Entry 0 is a constant zero, so writes to r0 vanish
    // without any extra qualification on the write enable.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_reg
                logic [XLEN-1:0] q_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        q_reg <= '0;
                    else if (wb_en && (rd_reg == 5'(gi)))
                        q_reg <= alu_res;
                end
                assign rf_q[gi] = q_reg;
            end
        end
    endgenerate

    assign dbg_data = rf_q[dbg_addr];

    // ------------------------------------------------------------------
    // Decode. Operands come straight from the register file at accept time;
    // the previous writeback has always landed by then.
    // ------------------------------------------------------------------
    assign dec_op1 = rf_q[instr[25:21]];

    always_comb begin
        dec_legal = 1'b1;
        dec_code  = 4'd0;
        dec_rd    = instr[20:16];
        dec_op2   = {{(XLEN-16){1'b0}}, instr[15:0]};
        if (instr[31:26] == 6'h00) begin
            dec_rd  = instr[15:11];
            dec_op2 = rf_q[instr[20:16]];
            case (instr[5:0])
                6'h20:   dec_code = 4'd1;
                6'h22:   dec_code = 4'd2;
                6'h24:   dec_code = 4'd3;
                6'h25:   dec_code = 4'd4;
                6'h26:   dec_code = 4'd5;
                6'h04:   dec_code = 4'd6;
                6'h06:   dec_code = 4'd7;
                6'h07:   dec_code = 4'd8;
                6'h2A:   dec_code = 4'd9;
                6'h28:   dec_code = 4'd10;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            case (instr[31:26])
                6'h08: begin
                    dec_code = 4'd1;
                    dec_op2  = {{(XLEN-16){instr[15]}}, instr[15:0]};
                end
                6'h0A: begin
                    dec_code = 4'd2;
                    dec_op2  = {{(XLEN-16){instr[15]}}, instr[15:0]};
                end
                6'h0C:   dec_code = 4'd3;
                6'h0D:   dec_code = 4'd4;
                6'h0E:   dec_code = 4'd5;
                default: dec_legal = 1'b0;
            endcase
        end
    end

    assign accept = instr_valid && instr_ready;
    // Last WAIT cycle: the ALU result is valid at the closing edge.
    assign wb_en  = (state_reg == S_WAIT) && (cnt_reg == CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = dec_legal ? S_ISSUE : S_ILL;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wb_en) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_ILL:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // instr_ready is gated by rst_n so it stays low for the whole reset.
    always_comb begin
        instr_ready = rst_n && (state_reg == S_IDLE);
        alu_EX      = (state_reg == S_ISSUE);
        done        = (state_reg == S_DONE);
        illegal     = (state_reg == S_ILL);
    end

    // ------------------------------------------------------------------
    // Datapath registers: ALU drive, destination, latency counter, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_i_reg  <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            rd_reg     <= '0;
            cnt_reg    <= '0;
            flag_c_reg <= 1'b0;
            flag_z_reg <= 1'b0;
        end else begin
            if (accept) begin
                alu_i_reg <= dec_code;
                op1_reg   <= dec_op1;
                op2_reg   <= dec_op2;
                rd_reg    <= dec_rd;
            end
            if (state_reg == S_ISSUE)
                cnt_reg <= CNT_W'(ALU_LATENCY);
            else if (state_reg == S_WAIT)
                cnt_reg <= cnt_reg - CNT_W'(1);
            // Flags load even when rd is r0.
            if (wb_en) begin
                flag_c_reg <= alu_carry;
                flag_z_reg <= alu_z;
            end
        end
    end

    assign alu_I   = alu_i_reg;
    assign alu_op1 = op1_reg;
    assign alu_op2 = op2_reg;
    assign flag_c  = flag_c_reg;
    assign flag_z  = flag_z_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed instruction sequence with a
// registered one-cycle ALU model, a reference decoder/register mirror and a
// writeback scoreboard checked on every done pulse.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  alu_I;
    logic        alu_EX;
    logic [31:0] alu_op1, alu_op2;
    logic [31:0] alu_res;
    logic        alu_carry, alu_z;
    logic        done, illegal, flag_c, flag_z;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    alu_issue_ctrl #(.XLEN(32), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_I(alu_I), .alu_EX(alu_EX), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_res(alu_res), .alu_carry(alu_carry), .alu_z(alu_z),
        .done(done), .illegal(illegal), .flag_c(flag_c), .flag_z(flag_z),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int n_acc_exp = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        c;
        logic        z;
    } wb_t;
    wb_t sb[$];

    logic [31:0] mregs [32];
    logic        mflag_c, mflag_z;

    // Reference ALU: {carry, result}
    function automatic logic [32:0] alu_fn(input logic [3:0] code,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] r;
        r = '0;
        case (code)
            4'd1:  r = {1'b0, a} + {1'b0, b};
            4'd2:  r = {1'b0, a} - {1'b0, b};
            4'd3:  r = {1'b0, a & b};
            4'd4:  r = {1'b0, a | b};
            4'd5:  r = {1'b0, a ^ b};
            4'd6:  r = {1'b0, a << b[4:0]};
            4'd7:  r = {1'b0, a >> b[4:0]};
            4'd8:  r = {1'b0, 32'($signed(a) >>> b[4:0])};
            4'd9:  r = {1'b0, 31'd0, ($signed(a) < $signed(b))};
            4'd10: r = {1'b0, 31'd0, (a == b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Registered one-cycle ALU model
    logic [32:0] alu_t;
    always_comb alu_t = alu_fn(alu_I, alu_op1, alu_op2);
    always @(posedge clk) begin
        if (alu_EX) begin
            alu_res   <= alu_t[31:0];
            alu_carry <= alu_t[32];
            alu_z     <= (alu_t[31:0] == 32'd0);
        end
    end

    always @(posedge clk) begin
        if (instr_valid && instr_ready) n_acc <= n_acc + 1;
    end

    // Reference decoder against the register mirror
    function automatic void ref_dec(input logic [31:0] w, output bit legal,
                                    output logic [3:0] code, output logic [4:0] rd,
                                    output logic [31:0] a, output logic [31:0] b);
        legal = 1'b1;
        code  = 4'd0;
        a     = mregs[w[25:21]];
        if (w[31:26] == 6'h00) begin
            rd = w[15:11];
            b  = mregs[w[20:16]];
            case (w[5:0])
                6'h20: code = 4'd1;   6'h22: code = 4'd2;
                6'h24: code = 4'd3;   6'h25: code = 4'd4;
                6'h26: code = 4'd5;   6'h04: code = 4'd6;
                6'h06: code = 4'd7;   6'h07: code = 4'd8;
                6'h2A: code = 4'd9;   6'h28: code = 4'd10;
                default: legal = 1'b0;
            endcase
        end else begin
            rd = w[20:16];
            b  = {16'd0, w[15:0]};
            case (w[31:26])
                6'h08: begin code = 4'd1; b = {{16{w[15]}}, w[15:0]}; end
                6'h0A: begin code = 4'd2; b = {{16{w[15]}}, w[15:0]}; end
                6'h0C: code = 4'd3;
                6'h0D: code = 4'd4;
                6'h0E: code = 4'd5;
                default: legal = 1'b0;
            endcase
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
        chk("ready_wait", 32'(instr_ready), 32'd1);
    endtask

    // Issue one instruction; with hold_junk, valid stays high with changing
    // words while the block is busy. Called on a falling edge.
    task automatic do_instr(input logic [31:0] w, input bit hold_junk);
        bit          legal;
        logic [3:0]  code;
        logic [4:0]  rd;
        logic [31:0] a, b;
        logic [32:0] r;
        wb_t         e;
        int          cyc, n_ex;

        ref_dec(w, legal, code, rd, a, b);
        wait_ready();
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        n_acc_exp++;
        if (legal) begin
            r     = alu_fn(code, a, b);
            e.rd  = rd;
            e.val = (rd == 5'd0) ? 32'd0 : r[31:0];
            e.c   = r[32];
            e.z   = (r[31:0] == 32'd0);
            sb.push_back(e);
        end
        @(negedge clk);
        if (hold_junk) instr = 32'h2007_0001;
        else instr_valid = 1'b0;
        cyc  = 1;
        n_ex = int'(alu_EX);
        if (legal) begin
            chk("alu_I", 32'(alu_I), 32'(code));
            chk("alu_op1", alu_op1, a);
            chk("alu_op2", alu_op2, b);
        end
        while (!done && !illegal && cyc < 10) begin
            @(negedge clk);
            cyc++;
            n_ex += int'(alu_EX);
            if (hold_junk) instr = 32'h2007_0000 | 32'(cyc);
        end
        instr_valid = 1'b0;
        if (legal) begin
            chk("done_latency", 32'(cyc), 32'd3);
            chk("done", 32'(done), 32'd1);
            chk("ex_cycles", 32'(n_ex), 32'd1);
            chk("no_illegal", 32'(illegal), 32'd0);
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                dbg_addr = e.rd;
                #1;
                chk("wb_data", dbg_data, e.val);
                chk("flag_c", 32'(flag_c), 32'(e.c));
                chk("flag_z", 32'(flag_z), 32'(e.z));
                if (e.rd != 5'd0) mregs[e.rd] = e.val;
                mflag_c = e.c;
                mflag_z = e.z;
            end
            $display("txn instr=%h rd=%0d res=%h c=%0d z=%0d", w, rd, dbg_data, flag_c, flag_z);
        end else begin
            chk("ill_latency", 32'(cyc), 32'd1);
            chk("illegal", 32'(illegal), 32'd1);
            chk("ill_no_done", 32'(done), 32'd0);
            @(negedge clk);
            chk("ill_ready", 32'(instr_ready), 32'd1);
            chk("ill_pulse_end", 32'(illegal), 32'd0);
            chk("ill_flag_c", 32'(flag_c), 32'(mflag_c));
            chk("ill_flag_z", 32'(flag_z), 32'(mflag_z));
            dbg_addr = rd;
            #1;
            chk("ill_reg", dbg_data, mregs[rd]);
            $display("txn instr=%h dropped as illegal", w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dseen;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mflag_c = 1'b0;
        mflag_z = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_ex", 32'(alu_EX), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(instr_ready), 32'd1);

        do_instr(32'h2001_000B, 1'b0);   // ADDI r1,r0,11
        do_instr(32'h2002_0002, 1'b0);   // ADDI r2,r0,2
        do_instr(32'h0022_1820, 1'b0);   // ADD  r3,r1,r2
        do_instr(32'h0041_2022, 1'b0);   // SUB  r4,r2,r1
        dbg_addr = 5'd3; #1; chk("r3_lit", dbg_data, 32'd13);
        dbg_addr = 5'd4; #1; chk("r4_lit", dbg_data, 32'hFFFF_FFF7);
        chk("flag_z_after_sub", 32'(flag_z), 32'd0);
        do_instr(32'h0021_2826, 1'b0);   // XOR  r5,r1,r1
        chk("flag_z_xor", 32'(flag_z), 32'd1);
        do_instr(32'h2000_0005, 1'b0);   // ADDI r0,r0,5
        dbg_addr = 5'd0; #1; chk("r0_zero", dbg_data, 32'd0);
        chk("flag_z_r0", 32'(flag_z), 32'd0);
        do_instr(32'h0082_4807, 1'b0);   // SRA  r9,r4,r2
        do_instr(32'h282A_FFFF, 1'b0);   // SUBI r10,r1,-1
        do_instr(32'h340B_8000, 1'b0);   // ORI  r11,r0,0x8000
        do_instr(32'hFC22_1820, 1'b0);   // op 0x3F
        do_instr(32'h0022_183F, 1'b0);   // func 0x3F

        // Upstream keeps valid high with new words while busy
        do_instr(32'h3028_0F0F, 1'b1);   // ANDI r8,r1,0xF0F
        repeat (2) @(negedge clk);
        chk("accepts", 32'(n_acc), 32'(n_acc_exp));
        dbg_addr = 5'd7; #1; chk("r7_untouched", dbg_data, 32'd0);

        // Reset during WAIT of ADDI r6,r0,7
        @(negedge clk);
        wait_ready();
        instr       = 32'h2006_0007;
        instr_valid = 1'b1;
        @(posedge clk);
        n_acc_exp++;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ex", 32'(alu_EX), 32'd0);
        chk("mid_rst_I", 32'(alu_I), 32'd0);
        chk("mid_rst_op1", alu_op1, 32'd0);
        chk("mid_rst_op2", alu_op2, 32'd0);
        chk("mid_rst_ready", 32'(instr_ready), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mflag_c = 1'b0;
        mflag_z = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        dbg_addr = 5'd6;
        #1;
        chk("r6_after_rst", dbg_data, 32'd0);
        dseen = 0;
        repeat (3) begin
            @(negedge clk);
            dseen += int'(done);
        end
        chk("no_done_after_rst", 32'(dseen), 32'd0);
        $display("txn instr=20060007 aborted by reset");
        do_instr(32'h2001_0003, 1'b0);   // ADDI r1,r0,3
        chk("accepts_final", 32'(n_acc), 32'(n_acc_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
